soc_mgmt_clk_div_bank: RTL

SOC_MGMT_CLK_DIV_BANK -- requirements
Module: soc_mgmt_clk_div_bank

---
 rtl/soc_mgmt_clk_div_bank.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/soc_mgmt_clk_div_bank.sv
// soc_mgmt_clk_div_bank
// Bank of independent programmable clock dividers. Each channel produces a
// registered divided clock with period cur_div cycles (high for
// floor(cur_div/2) cycles) plus a one-cycle tick at every period start.
// New divide values are staged per channel and only take effect at a period
// boundary, so a running clock never sees a runt phase.
//
// Ports:
//   i_clk        single clock, all state in this domain
//   i_rst        asynchronous active-high reset
//   i_div_en     per-channel enable
//   i_upd_valid  divide-value update request
//   i_upd_idx    target channel of the update
//   i_upd_value  new divide value
//   o_upd_ready  update can be accepted (combinational)
//   o_div_clk    registered divided clocks
//   o_div_pulse  one-cycle tick at each divided-clock period start
//   o_pending    per-channel update pending
//   o_active     per-channel running flag
module soc_mgmt_clk_div_bank #(
  parameter int NUM_DIV_CLK = 6,
  parameter int DIV_W       = 8,
  parameter int RESET_DIV   = 4,
  localparam int IDX_W      = (NUM_DIV_CLK > 1) ? $clog2(NUM_DIV_CLK) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_DIV_CLK-1:0] i_div_en,
  input  logic                   i_upd_valid,
  input  logic [IDX_W-1:0]       i_upd_idx,
  input  logic [DIV_W-1:0]       i_upd_value,
  output logic                   o_upd_ready,
  output logic [NUM_DIV_CLK-1:0] o_div_clk,
  output logic [NUM_DIV_CLK-1:0] o_div_pulse,
  output logic [NUM_DIV_CLK-1:0] o_pending,
  output logic [NUM_DIV_CLK-1:0] o_active
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(RESET_DIV);
  localparam logic [DIV_W-1:0] MIN_RUN = DIV_W'(2);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [IDX_W:0]   NUM_CH  = (IDX_W+1)'(NUM_DIV_CLK);

  logic [NUM_DIV_CLK-1:0] pend_vec;
  logic                   idx_ok;
  logic                   idx_pend;
  logic                   upd_fire;

  // Look up the pending flag of the addressed channel without indexing
  // past the end of the vector for out-of-range indices.
  always_comb begin
    idx_pend = 1'b0;
    for (int k = 0; k < NUM_DIV_CLK; k++) begin
      if (i_upd_idx == IDX_W'(k)) begin
        idx_pend = pend_vec[k];
      end
    end
  end

  assign idx_ok      = ({1'b0, i_upd_idx} < NUM_CH);
  assign o_upd_ready = idx_ok && !idx_pend;
  assign upd_fire    = i_upd_valid && o_upd_ready;
  assign o_pending   = pend_vec;

  for (genvar gi = 0; gi < NUM_DIV_CLK; gi++) begin : g_ch
    logic [DIV_W-1:0] cur_div_reg;
    logic [DIV_W-1:0] nxt_div_reg;
    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W-1:0] start_div;
    logic             pend_reg;
    logic             clk_reg;
    logic             pulse_reg;
    logic             active_reg;
    logic             accept;
    logic             wrap;
    logic             start;

    assign accept  = upd_fire && (i_upd_idx == IDX_W'(gi));
    assign wrap    = (cnt_reg == cur_div_reg - ONE);
    assign cnt_inc = cnt_reg + ONE;
    // A stopped channel with a staged value starts directly with that value,
    // since the staged value is committed on the same edge.
    assign start_div = pend_reg ? nxt_div_reg : cur_div_reg;
    assign start     = i_div_en[gi] && (start_div >= MIN_RUN);

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        cur_div_reg <= RST_DIV;
        nxt_div_reg <= RST_DIV;
        pend_reg    <= 1'b0;
        cnt_reg     <= '0;
        clk_reg     <= 1'b0;
        pulse_reg   <= 1'b0;
        active_reg  <= 1'b0;
      end else begin
        // accept only fires when pend_reg is clear, so it never collides
        // with the commit paths below that clear pend_reg.
        if (accept) begin
          nxt_div_reg <= i_upd_value;
          pend_reg    <= 1'b1;
        end

        if (!active_reg) begin
          if (pend_reg) begin
            cur_div_reg <= nxt_div_reg;
            pend_reg    <= 1'b0;
          end
          cnt_reg    <= '0;
          clk_reg    <= start;
          pulse_reg  <= start;
          active_reg <= start;
        end else if (!i_div_en[gi]) begin
          // Disable truncates the current phase immediately.
          cnt_reg    <= '0;
          clk_reg    <= 1'b0;
          pulse_reg  <= 1'b0;
          active_reg <= 1'b0;
        end else if (wrap) begin
          cnt_reg <= '0;
          if (pend_reg) begin
            // Commit at the period boundary; a value below 2 stops here.
            cur_div_reg <= nxt_div_reg;
            pend_reg    <= 1'b0;
            clk_reg     <= (nxt_div_reg >= MIN_RUN);
            pulse_reg   <= (nxt_div_reg >= MIN_RUN);
            active_reg  <= (nxt_div_reg >= MIN_RUN);
          end else begin
            clk_reg   <= 1'b1;
            pulse_reg <= 1'b1;
          end
        end else begin
          cnt_reg   <= cnt_inc;
          clk_reg   <= (cnt_inc < (cur_div_reg >> 1));
          pulse_reg <= 1'b0;
        end
      end
    end

    assign pend_vec[gi]    = pend_reg;
    assign o_div_clk[gi]   = clk_reg;
    assign o_div_pulse[gi] = pulse_reg;
    assign o_active[gi]    = active_reg;
  end

endmodule
